// File: rtl/imu_sample_scaler_pkg.sv
// Shared types and elaboration helpers for the IMU sample scaler: FSM encoding,
// index-width and product-width helpers.
package imu_sample_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single-channel build still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Exact width of (x - bias) * gain.
  function automatic int prod_width(input int in_w, input int coef_w);
    return in_w + 1 + coef_w;
  endfunction

endpackage

// File: rtl/imu_scale_lane.sv
// Combinational datapath for one channel:
// y = sat(round_half_away((x - bias) * gain / 2^SHIFT)).
module imu_scale_lane
  import imu_sample_scaler_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int COEF_W = 18,
  parameter int SHIFT  = 12
) (
  input  logic signed [IN_W-1:0]   x,
  input  logic signed [IN_W-1:0]   bias,
  input  logic signed [COEF_W-1:0] gain,
  output logic signed [OUT_W-1:0]  y,
  output logic                     sat
);

  localparam int PW = prod_width(IN_W, COEF_W);
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]   diff;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   pext;
  logic signed [RW-1:0]   rnd;

  assign diff = {x[IN_W-1], x} - {bias[IN_W-1], bias};
  assign prod = $signed({{COEF_W{diff[IN_W]}}, diff}) * $signed({{(IN_W+1){gain[COEF_W-1]}}, gain});
  assign pext = {prod[PW-1], prod};

  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd = pext;
    end else begin : g_round
      localparam logic [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};
      localparam logic [RW-1:0] HALF = ONE << (SHIFT - 1);
      logic [RW-1:0] bump;
      // Negative values use half-1 so the floor shift rounds ties away from zero.
      assign bump = pext[RW-1] ? (HALF - ONE) : HALF;
      assign rnd  = (pext + $signed(bump)) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    y   = rnd[OUT_W-1:0];
    sat = 1'b0;
    if (rnd > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (rnd < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end else begin
      y   = rnd[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/imu_sample_scaler.sv
// Frame-serial IMU scaler: captures N_CH raw samples, scales them one channel
// per cycle through a shared lane, then presents the whole frame downstream.
module imu_sample_scaler
  import imu_sample_scaler_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int COEF_W   = 18,
  parameter int SHIFT    = 12,
  parameter int GAIN_RST = 4096,
  localparam int SEL_W   = sel_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [N_CH*IN_W-1:0]    s_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [N_CH*OUT_W-1:0]   m_tdata,
  output logic [N_CH-1:0]         m_tuser,
  input  logic                    cfg_we,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic [COEF_W-1:0]       cfg_gain,
  input  logic [IN_W-1:0]         cfg_bias,
  output logic                    cfg_ready
);

  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_LIM = (SEL_W + 1)'(N_CH);

  state_t                 state_r, state_nx;
  logic [SEL_W-1:0]       idx_r;
  logic [N_CH*IN_W-1:0]   data_r;
  logic [N_CH*OUT_W-1:0]  out_r;
  logic [N_CH-1:0]        user_r;
  logic [COEF_W-1:0]      gain_r [N_CH];
  logic [IN_W-1:0]        bias_r [N_CH];
  logic [OUT_W-1:0]       lane_y;
  logic                   lane_sat;

  assign s_tready  = (state_r == IDLE);
  assign cfg_ready = (state_r == IDLE);
  assign m_tvalid  = (state_r == OUT);
  assign m_tdata   = out_r;
  assign m_tuser   = user_r;

  imu_scale_lane #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .COEF_W (COEF_W),
    .SHIFT  (SHIFT)
  ) u_lane (
    .x    (data_r[idx_r*IN_W +: IN_W]),
    .bias (bias_r[idx_r]),
    .gain (gain_r[idx_r]),
    .y    (lane_y),
    .sat  (lane_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = s_tvalid ? CALC : IDLE;
      CALC:    state_nx = (idx_r == LAST) ? OUT : CALC;
      OUT:     state_nx = m_tready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r  <= '0;
      data_r <= '0;
      out_r  <= '0;
      user_r <= '0;
    end else begin
      if (state_r == IDLE && s_tvalid) begin
        data_r <= s_tdata;
        idx_r  <= '0;
      end
      // Results land in the output register directly; it is only visible once OUT is reached.
      if (state_r == CALC) begin
        out_r[idx_r*OUT_W +: OUT_W] <= lane_y;
        user_r[idx_r]               <= lane_sat;
        idx_r                       <= idx_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        gain_r[i] <= COEF_W'(GAIN_RST);
        bias_r[i] <= '0;
      end
    end else if (cfg_we && state_r == IDLE && {1'b0, cfg_sel} < N_LIM) begin
      gain_r[cfg_sel] <= cfg_gain;
      bias_r[cfg_sel] <= cfg_bias;
    end
  end

endmodule

// File: tb/tb_imu_sample_scaler.sv
// Directed self-checking bench for imu_sample_scaler with default parameters (N_CH=5).
module tb_imu_sample_scaler;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid;
  logic        s_tready;
  logic [79:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [79:0] m_tdata;
  logic [4:0]  m_tuser;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [17:0] cfg_gain;
  logic [15:0] cfg_bias;
  logic        cfg_ready;

  int tests = 0;
  int fails = 0;

  imu_sample_scaler dut (
    .clk       (clk),
    .reset     (reset),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tuser   (m_tuser),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_gain  (cfg_gain),
    .cfg_bias  (cfg_bias),
    .cfg_ready (cfg_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pk(input logic [15:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input logic [17:0] g, input logic [15:0] b);
    cfg_we = 1'b1; cfg_sel = 3'(ch); cfg_gain = g; cfg_bias = b;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_all(input logic [17:0] g, input logic [15:0] b);
    for (int i = 0; i < 5; i++) write_cfg(i, g, b);
  endtask

  task automatic send_frame(input logic [79:0] d);
    int n;
    n = 0;
    while (!s_tready && n < 30) begin step(); n++; end
    s_tdata = d; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
  endtask

  // Called from cycle T+1; returns the cycle offset at which m_tvalid was seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!m_tvalid && lat < 20) begin step(); lat++; end
    tests++;
    if (!m_tvalid) begin
      fails++;
      $display("FAIL wait_valid: m_tvalid never rose (waited %0d cycles, required 6)", lat);
    end
  endtask

  task automatic take_output();
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    tests++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL take_output: s_tready=%b m_tvalid=%b, required 1/0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    tests++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== 80'd0 || m_tuser !== 5'd0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: s_tready=%b m_tvalid=%b m_tdata=%h m_tuser=%b cfg_ready=%b, required 1 0 0 0 1",
               s_tready, m_tvalid, m_tdata, m_tuser, cfg_ready);
    end
  endtask

  task automatic test_passthrough();
    int lat;
    logic [79:0] exp_d;
    exp_d = pk(16'd1234, -16'sd1234, 16'd0, 16'd0, 16'd0);
    send_frame(pk(16'd1234, -16'sd1234, 16'd0, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (lat !== 6) begin
      fails++;
      $display("FAIL passthrough_latency: got %0d, required 6", lat);
    end
    tests++;
    if (m_tdata !== exp_d || m_tuser !== 5'd0) begin
      fails++;
      $display("FAIL passthrough_data: got %h/%b, required %h/00000", m_tdata, m_tuser, exp_d);
    end
    take_output();
  endtask

  task automatic test_rounding();
    int lat;
    logic [79:0] exp_d;
    set_all(18'd6144, 16'd0);
    exp_d = pk(16'd5, -16'sd5, 16'd2, 16'd0, 16'd0);
    send_frame(pk(16'd3, -16'sd3, 16'd1, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d || m_tuser !== 5'd0) begin
      fails++;
      $display("FAIL rounding: got %h/%b, required %h/00000", m_tdata, m_tuser, exp_d);
    end
    take_output();
  endtask

  task automatic test_saturation();
    int lat;
    logic [79:0] exp_d;
    set_all(18'd8192, 16'd0);
    exp_d = pk(16'h7fff, 16'h8000, 16'd0, 16'd0, 16'd0);
    send_frame(pk(16'd20000, -16'sd20000, 16'd0, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d || m_tuser !== 5'b00011) begin
      fails++;
      $display("FAIL saturation: got %h/%b, required %h/00011", m_tdata, m_tuser, exp_d);
    end
    take_output();
    set_all(18'd4096, 16'd0);
    write_cfg(0, 18'd4096, 16'h8000);
    exp_d = pk(16'h7fff, 16'd7, 16'd0, 16'd0, 16'd0);
    send_frame(pk(16'd32767, 16'd7, 16'd0, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d || m_tuser !== 5'b00001) begin
      fails++;
      $display("FAIL sat_bias_extreme: got %h/%b, required %h/00001", m_tdata, m_tuser, exp_d);
    end
    take_output();
    write_cfg(0, 18'd4096, 16'd0);
  endtask

  task automatic test_bias_and_cfg_ignore();
    int lat;
    logic [79:0] exp_d;
    write_cfg(2, 18'd4096, 16'd100);
    exp_d = pk(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    send_frame(pk(16'd0, 16'd0, 16'd100, 16'd0, 16'd0));
    // Attempt a coefficient write in the middle of CALC.
    cfg_we = 1'b1; cfg_sel = 3'd2; cfg_gain = 18'd8192; cfg_bias = 16'd0;
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL cfg_ready_calc: got %b, required 0", cfg_ready);
    end
    step(); step();
    cfg_we = 1'b0;
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d) begin
      fails++;
      $display("FAIL bias_zero: got %h, required %h", m_tdata, exp_d);
    end
    take_output();
    exp_d = pk(16'd0, 16'd0, -16'sd1, 16'd0, 16'd0);
    send_frame(pk(16'd0, 16'd0, 16'd99, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d || m_tuser !== 5'd0) begin
      fails++;
      $display("FAIL bias_minus_one_cfg_ignored: got %h/%b, required %h/00000", m_tdata, m_tuser, exp_d);
    end
    take_output();
    write_cfg(2, 18'd4096, 16'd0);
  endtask

  task automatic test_same_cycle_cfg();
    int lat;
    logic [79:0] exp_d;
    exp_d = pk(16'd200, 16'd50, 16'd0, 16'd0, 16'd0);
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_gain = 18'd8192; cfg_bias = 16'd0;
    send_frame(pk(16'd100, 16'd50, 16'd0, 16'd0, 16'd0));
    cfg_we = 1'b0;
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d) begin
      fails++;
      $display("FAIL same_cycle_cfg: got %h, required %h", m_tdata, exp_d);
    end
    take_output();
    write_cfg(0, 18'd4096, 16'd0);
  endtask

  task automatic test_back_to_back();
    int lat, last_hs, n_hs, n_out, bad_stall, bad_gap, bad_out;
    logic [79:0] exp_d;
    exp_d = pk(16'd11, -16'sd22, 16'd33, -16'sd44, 16'd55);
    send_frame(exp_d);
    wait_valid(lat);
    bad_stall = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_tvalid !== 1'b1 || s_tready !== 1'b0 || m_tdata !== exp_d) bad_stall++;
      step();
    end
    tests++;
    if (bad_stall != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad_stall);
    end
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = exp_d;
    last_hs = -1; n_hs = 0; n_out = 0; bad_gap = 0; bad_out = 0;
    for (int c = 0; c < 30; c++) begin
      if (s_tvalid && s_tready) begin
        if (last_hs >= 0 && c - last_hs != 7) bad_gap++;
        last_hs = c;
        n_hs++;
      end
      if (m_tvalid && m_tready) begin
        n_out++;
        if (m_tdata !== exp_d || m_tuser !== 5'd0) bad_out++;
      end
      step();
    end
    s_tvalid = 1'b0;
    tests++;
    if (bad_gap != 0 || n_hs < 4) begin
      fails++;
      $display("FAIL b2b_period: %0d handshakes, %0d wrong gaps, required >=4 and 0", n_hs, bad_gap);
    end
    tests++;
    if (bad_out != 0 || n_out < 4) begin
      fails++;
      $display("FAIL b2b_data: %0d outputs, %0d wrong, required >=4 and 0", n_out, bad_out);
    end
    // Drain whatever frame is in flight.
    lat = 0;
    while (!s_tready && lat < 20) begin step(); lat++; end
    m_tready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int lat, seen;
    logic [79:0] exp_d;
    write_cfg(0, 18'd8192, 16'd0);
    send_frame(pk(16'd1000, 16'd0, 16'd0, 16'd0, 16'd0));
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_frame: m_tvalid=%b s_tready=%b, required 0/1", m_tvalid, s_tready);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_tvalid) seen++;
      step();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL aborted_frame_emitted: m_tvalid high %0d cycles, required 0", seen);
    end
    exp_d = pk(16'd1000, 16'd0, 16'd0, 16'd0, 16'd0);
    send_frame(pk(16'd1000, 16'd0, 16'd0, 16'd0, 16'd0));
    wait_valid(lat);
    tests++;
    if (m_tdata !== exp_d) begin
      fails++;
      $display("FAIL gain_after_reset: got %h, required %h", m_tdata, exp_d);
    end
    take_output();
  endtask

  initial begin
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_gain = '0; cfg_bias = '0;
    test_reset();
    test_passthrough();
    test_rounding();
    test_saturation();
    test_bias_and_cfg_ignore();
    test_same_cycle_cfg();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
